// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and the saturating EX-occupancy load value
// used by the hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned CNT_W     = 4;

    // Cycles until WB for a producer entering EX: occupancy + 1, clipped to
    // the largest value a cw-bit counter can hold.
    function automatic int unsigned sat_load(input int unsigned ex_cycles,
                                             input int unsigned cw);
        int unsigned lim;
        lim = (32'd1 << cw) - 32'd1;
        return ((ex_cycles + 32'd1) > lim) ? lim : (ex_cycles + 32'd1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bundle and scoreboard responses between the pipeline
// control (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned NREGS = hazard_scoreboard_pkg::NUM_REGS,
    parameter int unsigned CW    = hazard_scoreboard_pkg::CNT_W
) ();
    import hazard_scoreboard_pkg::*;

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [REG_IDX_W-1:0] id_rd;
    logic                 id_reg_write;
    logic [CW-1:0]        id_ex_cycles;
    logic                 hold;
    logic                 ex_flush;
    logic                 stall;
    logic [NREGS-1:0]     busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_ex_cycles, hold, ex_flush,
        input  stall, busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_ex_cycles, hold, ex_flush,
        output stall, busy
    );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's in-flight write counter: cycles remaining
// until its newest producer occupies WB.
module sb_entry #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          restore,
    input  logic [CW-1:0] restore_val,
    output logic [CW-1:0] cnt,
    output logic          busy
);

    logic [CW-1:0] cnt_dec;
    logic [CW-1:0] restore_dec;
    logic [CW-1:0] waw_val;

    always_comb begin
        cnt_dec     = (cnt != '0) ? cnt - CW'(1) : '0;
        restore_dec = (restore_val != '0) ? restore_val - CW'(1) : '0;
        // A newer writer never shortens an older, longer in-flight write.
        waw_val     = (cnt_dec > load_val) ? cnt_dec : load_val;
        busy        = (cnt != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restore) begin
            cnt <= restore_dec;
        end else if (load) begin
            cnt <= waw_val;
        end else if (!hold) begin
            cnt <= cnt_dec;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker: stalls ID while a source producer
// will not be forwardable from MEM/WB by the time the consumer reaches EX.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS = NUM_REGS,
    parameter int unsigned CW    = CNT_W
) (
    input logic              clk,
    input logic              rst,
    hazard_scoreboard_if.slave bus
);

    logic [CW-1:0]        cnt [NREGS];
    logic                 entry_busy [NREGS];
    logic                 hit1;
    logic                 hit2;
    logic                 stall;
    logic                 issue;
    logic                 wr;
    logic                 restore;
    logic [CW-1:0]        load_val;
    logic [CW-1:0]        rd_dec;
    logic                 last_vld;
    logic [REG_IDX_W-1:0] last_rd;
    logic [CW-1:0]        last_prev;

    always_comb begin
        hit1     = bus.id_use_rs1 && (bus.id_rs1 != '0) && (cnt[bus.id_rs1] >= CW'(2));
        hit2     = bus.id_use_rs2 && (bus.id_rs2 != '0) && (cnt[bus.id_rs2] >= CW'(2));
        stall    = bus.id_valid && (hit1 || hit2);
        issue    = bus.id_valid && !stall && !bus.hold && !bus.ex_flush;
        wr       = issue && bus.id_reg_write && (bus.id_rd != '0);
        restore  = bus.ex_flush && last_vld;
        load_val = CW'(sat_load(32'(bus.id_ex_cycles), CW));
        rd_dec   = (cnt[bus.id_rd] != '0) ? cnt[bus.id_rd] - CW'(1) : '0;
    end

    always_comb begin
        bus.stall = stall;
        bus.busy  = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            bus.busy[r] = entry_busy[r];
        end
    end

    assign cnt[0]        = '0;
    assign entry_busy[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        localparam logic [REG_IDX_W-1:0] IDX = REG_IDX_W'(r);
        sb_entry #(.CW(CW)) u_entry (
            .clk         (clk),
            .rst         (rst),
            .hold        (bus.hold),
            .load        (wr && (bus.id_rd == IDX)),
            .load_val    (load_val),
            .restore     (restore && (last_rd == IDX)),
            .restore_val (last_prev),
            .cnt         (cnt[r]),
            .busy        (entry_busy[r])
        );
    end

    // Remembers the write that just entered EX so a flush of it can hand the
    // register back to the older producer it displaced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_vld  <= 1'b0;
            last_rd   <= '0;
            last_prev <= '0;
        end else if (restore) begin
            last_vld <= 1'b0;
        end else if (wr) begin
            last_vld  <= 1'b1;
            last_rd   <= bus.id_rd;
            last_prev <= rd_dec;
        end else if (!bus.hold) begin
            last_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random issue
// traffic, checked every cycle against a rule-level scoreboard model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NR   = 32;
    localparam int CWT  = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hazard_scoreboard_if #(.NREGS(NR), .CW(CWT)) bus ();
    hazard_scoreboard #(.NREGS(NR), .CW(CWT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    int m_cnt [NR];
    bit m_lvld;
    int m_lrd;
    int m_lprev;

    function automatic int dec(input int v);
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic bit m_stall();
        bit h1, h2;
        h1 = bus.id_use_rs1 && (bus.id_rs1 != 0) && (m_cnt[bus.id_rs1] >= 2);
        h2 = bus.id_use_rs2 && (bus.id_rs2 != 0) && (m_cnt[bus.id_rs2] >= 2);
        return bus.id_valid && (h1 || h2);
    endfunction

    function automatic logic [NR-1:0] m_busy();
        logic [NR-1:0] b;
        for (int r = 0; r < NR; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_lvld = 1'b0;
        m_lrd = 0;
        m_lprev = 0;
    endtask

    task automatic model_edge();
        int nxt [NR];
        bit iss, wr, rest;
        int l;
        iss  = bus.id_valid && !m_stall() && !bus.hold && !bus.ex_flush;
        wr   = iss && bus.id_reg_write && (bus.id_rd != 0);
        rest = bus.ex_flush && m_lvld;
        l = int'(bus.id_ex_cycles) + 1;
        if (l > CMAX) l = CMAX;
        for (int r = 0; r < NR; r++) nxt[r] = bus.hold ? m_cnt[r] : dec(m_cnt[r]);
        if (rest) nxt[m_lrd] = dec(m_lprev);
        if (wr) begin
            int d;
            d = dec(m_cnt[bus.id_rd]);
            nxt[bus.id_rd] = (d > l) ? d : l;
            m_lprev = d;
            m_lrd = int'(bus.id_rd);
            m_lvld = 1'b1;
        end else if (rest || !bus.hold) begin
            m_lvld = 1'b0;
        end
        nxt[0] = 0;
        for (int r = 0; r < NR; r++) m_cnt[r] = nxt[r];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc_stall", 64'(bus.stall), 64'(m_stall()));
            chk("cyc_busy", 64'(bus.busy), 64'(m_busy()));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit we, input int exc,
                          input bit h, input bit f);
        bus.id_valid     = v;
        bus.id_rs1       = 5'(rs1);
        bus.id_use_rs1   = u1;
        bus.id_rs2       = 5'(rs2);
        bus.id_use_rs2   = u2;
        bus.id_rd        = 5'(rd);
        bus.id_reg_write = we;
        bus.id_ex_cycles = 4'(exc);
        bus.hold         = h;
        bus.ex_flush     = f;
    endtask

    task automatic idle();                    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic issue_w(input int rd, input int exc); set_in(1, 0, 0, 0, 0, rd, 1, exc, 0, 0); endtask
    task automatic rd1(input int rs);         set_in(1, rs, 1, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic flush_only();              set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); endtask

    task automatic count_stalls(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (!bus.stall) break;
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        idle();
        m_reset();
        #2;
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        #10 rst = 1'b1;
        checking = 1'b1;
        tick();

        // ALU producer followed by a dependent reader.
        issue_w(5, 1);
        #1 chk("s1_no_stall", 64'(bus.stall), 64'd0);
        tick();
        rd1(5);
        #1 chk("s1_stall", 64'(bus.stall), 64'd1);
        chk("s1_busy5", 64'(bus.busy[5]), 64'd1);
        tick();
        #1 chk("s1_release", 64'(bus.stall), 64'd0);
        tick();
        idle();
        #1 chk("s1_busy5_clr", 64'(bus.busy[5]), 64'd0);
        tick();

        // 4-cycle divide with back-to-back dependent.
        issue_w(7, 4);
        tick();
        rd1(7);
        count_stalls(n);
        chk("s2_stall_cycles", 64'(n), 64'd4);
        chk("s2_busy7_late", 64'(bus.busy[7]), 64'd1);
        tick();
        idle();
        #1 chk("s2_busy7_clr", 64'(bus.busy[7]), 64'd0);
        tick();

        // WAW: short writer after long writer keeps the longer completion.
        issue_w(3, 4);
        tick();
        issue_w(3, 1);
        #1 chk("s3_waw_no_stall", 64'(bus.stall), 64'd0);
        tick();
        rd1(3);
        count_stalls(n);
        chk("s3_waw_stalls", 64'(n), 64'd3);
        tick();
        idle();
        tick();

        // Flush of a fresh ALU write to an idle register.
        issue_w(9, 1);
        tick();
        flush_only();
        tick();
        rd1(9);
        #1 chk("s4_flush_stall", 64'(bus.stall), 64'd0);
        chk("s4_flush_busy9", 64'(bus.busy[9]), 64'd0);
        tick();
        // Flush with an older producer still at cnt 3.
        issue_w(9, 3);
        tick();
        idle();
        tick();
        issue_w(9, 1);
        tick();
        flush_only();
        tick();
        rd1(9);
        #1 chk("s4_restore_stall", 64'(bus.stall), 64'd0);
        chk("s4_restore_busy9", 64'(bus.busy[9]), 64'd1);
        tick();
        // Flush of a longer op that displaced a nearly-done producer.
        issue_w(9, 1);
        tick();
        issue_w(9, 3);
        tick();
        flush_only();
        tick();
        rd1(9);
        #1 chk("s4_restore_short", 64'(bus.busy[9]), 64'd0);
        tick();
        idle();
        tick();

        // Hold freezes counters while stall keeps evaluating.
        issue_w(4, 1);
        tick();
        set_in(1, 4, 1, 0, 0, 0, 0, 1, 1, 0);
        #1 chk("s5_hold_stall0", 64'(bus.stall), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 chk("s5_hold_stall", 64'(bus.stall), 64'd1);
        end
        rd1(4);
        #1 chk("s5_release_stall", 64'(bus.stall), 64'd1);
        tick();
        #1 chk("s5_after_release", 64'(bus.stall), 64'd0);
        tick();
        idle();
        tick();

        // Async reset in the middle of a stall.
        issue_w(6, 4);
        tick();
        rd1(6);
        #1 chk("s6_pre_rst_stall", 64'(bus.stall), 64'd1);
        rst = 1'b0;
        m_reset();
        #1 chk("s6_rst_stall", 64'(bus.stall), 64'd0);
        chk("s6_rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b1;
        tick();
        issue_w(0, 3);
        tick();
        idle();
        #1 chk("s6_rd0_busy", 64'(bus.busy), 64'd0);
        tick();

        for (int c = 0; c < 4000; c++) begin
            int exc;
            exc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 3));
            set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, exc, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b0;
                m_reset();
                #1 rst = 1'b1;
            end
            tick();
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
